// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one async-read RAM between fetch (p0) and load/store (p1); 1-cycle response.
// Backpressure is via pN_req_ready only; responses are unbuffered single-cycle pulses.
module ram_arbiter #(
  parameter int W  = 32,
  parameter int L  = 64,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req_valid,
  output logic                 p0_req_ready,
  input  logic [AW-1:0]        p0_req_addr,
  input  logic                 p0_req_wen,
  input  logic [W-1:0]         p0_req_wdata,
  output logic                 p0_rsp_valid,
  output logic [W-1:0]         p0_rsp_data,
  output logic                 p0_rsp_err,
  input  logic                 p1_req_valid,
  output logic                 p1_req_ready,
  input  logic [AW-1:0]        p1_req_addr,
  input  logic                 p1_req_wen,
  input  logic [W-1:0]         p1_req_wdata,
  output logic                 p1_rsp_valid,
  output logic [W-1:0]         p1_rsp_data,
  output logic                 p1_rsp_err,
  output logic [$clog2(L)-1:0] ram_addr,
  output logic                 ram_wr_ena,
  output logic [W-1:0]         ram_wr_data,
  input  logic [W-1:0]         ram_rd_data
);
  localparam int IW = $clog2(L);
  localparam logic [AW-3:0] LIM = (AW-2)'(L);

  logic          req0, req1, gnt0, gnt1, grant, sel_wen, err;
  logic [AW-1:0] sel_addr;
  logic [W-1:0]  sel_wdata;
  logic [IW-1:0] idx;

  logic          last_grant_q, last_grant_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic [W-1:0]  rsp_data0_q, rsp_data0_d;
  logic [W-1:0]  rsp_data1_q, rsp_data1_d;

  // Requests are masked while rst is high so nothing is granted or written.
  always_comb begin
    req0      = p0_req_valid & ~rst;
    req1      = p1_req_valid & ~rst;
    gnt0      = req0 & (~req1 | last_grant_q);
    gnt1      = req1 & (~req0 | ~last_grant_q);
    grant     = gnt0 | gnt1;
    sel_addr  = gnt1 ? p1_req_addr  : p0_req_addr;
    sel_wen   = gnt1 ? p1_req_wen   : p0_req_wen;
    sel_wdata = gnt1 ? p1_req_wdata : p0_req_wdata;
    idx       = sel_addr[IW+1:2];
    err       = (sel_addr[1:0] != 2'b00) | (sel_addr[AW-1:2] >= LIM);
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign ram_addr     = (grant & ~err) ? idx : '0;
  assign ram_wr_data  = grant ? sel_wdata : '0;
  assign ram_wr_ena   = grant & sel_wen & ~err;

  always_comb begin
    last_grant_d = grant ? gnt1 : last_grant_q;
    rsp_valid_d  = {gnt1, gnt0};
    rsp_err_d    = {gnt1 & err, gnt0 & err};
    rsp_data0_d  = rsp_data0_q;
    rsp_data1_d  = rsp_data1_q;
    if (gnt0) rsp_data0_d = (sel_wen | err) ? '0 : ram_rd_data;
    if (gnt1) rsp_data1_d = (sel_wen | err) ? '0 : ram_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_data0_q  <= '0;
      rsp_data1_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data0_q  <= rsp_data0_d;
      rsp_data1_q  <= rsp_data1_d;
    end
  end

  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_err   = rsp_err_q[0];
  assign p1_rsp_err   = rsp_err_q[1];
  assign p0_rsp_data  = rsp_data0_q;
  assign p1_rsp_data  = rsp_data1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: arbiter in front of a 64x32 async-read RAM model, responses checked by a scoreboard.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_wen, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_data;
  logic        p1_req_valid, p1_req_ready, p1_req_wen, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_data;
  logic [5:0]  ram_addr;
  logic        ram_wr_ena;
  logic [31:0] ram_wr_data, ram_rd_data;

  logic [31:0] mem [64];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  ram_arbiter #(.W(32), .L(64), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
    .p0_req_wen(p0_req_wen), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_data(p0_rsp_data), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
    .p1_req_wen(p1_req_wen), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_data(p1_rsp_data), .p1_rsp_err(p1_rsp_err),
    .ram_addr(ram_addr), .ram_wr_ena(ram_wr_ena), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // distributed RAM: synchronous write, asynchronous read
  assign ram_rd_data = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int port, input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.due  = cyc + 1;
    if (port == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic drive(input int port, input logic v, input logic [31:0] a,
                       input logic we, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_addr = a; p0_req_wen = we; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_addr = a; p1_req_wen = we; p1_req_wdata = wd;
    end
  endtask

  function automatic logic rdy(input int port);
    return (port == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  // Single request: wait (bounded) for ready, check the RAM-side decode, queue the response.
  task automatic req(input int port, input logic [31:0] addr, input logic we,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input logic [31:0] exp_ra, input string nm);
    int n;
    @(negedge clk);
    drive(port, 1'b1, addr, we, wd);
    #1;
    n = 0;
    while (!rdy(port) && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy(port)) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: got ready=0 expected 1", nm);
    end else begin
      chk({nm, "_ram_addr"}, 32'(ram_addr), exp_ra);
      chk({nm, "_wr_ena"}, 32'(ram_wr_ena), 32'(we & ~exp_e));
      push(port, exp_d, exp_e);
    end
    @(negedge clk);
    drive(port, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every response pulse must match the oldest expectation for its port.
  always @(negedge clk) begin
    if (p0_rsp_valid) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL p0_unexpected_rsp: got valid=1 expected no response");
      end else begin
        m0 = q0.pop_front();
        chk("p0_rsp_data", p0_rsp_data, m0.data);
        chk("p0_rsp_err", 32'(p0_rsp_err), 32'(m0.err));
        chk("p0_rsp_cycle", 32'(cyc), 32'(m0.due));
      end
    end
    if (p1_rsp_valid) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL p1_unexpected_rsp: got valid=1 expected no response");
      end else begin
        m1 = q1.pop_front();
        chk("p1_rsp_data", p1_rsp_data, m1.data);
        chk("p1_rsp_err", 32'(p1_rsp_err), 32'(m1.err));
        chk("p1_rsp_cycle", 32'(cyc), 32'(m1.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1;
    drive(0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFF);
    drive(1, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFF);

    // 1: reset holds everything quiet even with valid requests present
    repeat (2) @(negedge clk);
    #1;
    chk("rst_p0_ready", 32'(p0_req_ready), 32'h0);
    chk("rst_p1_ready", 32'(p1_req_ready), 32'h0);
    chk("rst_wr_ena", 32'(ram_wr_ena), 32'h0);
    chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'h0);
    chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 32'h0);
    chk("rst_p0_rsp_data", p0_rsp_data, 32'h0);
    chk("rst_p1_rsp_err", 32'(p1_rsp_err), 32'h0);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 2: write then read back
    req(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'd4, "t2_wr");
    req(0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'd4, "t2_rd");

    // 3: p1 write leaves last_grant=1, then both held valid alternate p0,p1,...
    req(1, 32'h4, 1'b1, 32'h1111_1111, 32'h0, 1'b0, 32'd1, "t3_pre");
    @(negedge clk);
    drive(0, 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1, 1'b1, 32'h4, 1'b0, 32'h0);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_p0_ready_%0d", i), 32'(p0_req_ready), 32'((i % 2) == 0));
      chk($sformatf("rr_p1_ready_%0d", i), 32'(p1_req_ready), 32'((i % 2) == 1));
      if ((i % 2) == 0) push(0, 32'h0, 1'b0);
      else push(1, 32'h1111_1111, 1'b0);
      @(negedge clk);
      if (i == 5) begin
        drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      #1;
    end

    // 4: after a p0 grant, p1 write beats p0 read of the same word; read sees new data
    req(0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0, "t4_pre");
    @(negedge clk);
    drive(1, 1'b1, 32'h20, 1'b1, 32'h1234_5678);
    drive(0, 1'b1, 32'h20, 1'b0, 32'h0);
    #1;
    chk("t4_p1_ready", 32'(p1_req_ready), 32'h1);
    chk("t4_p0_ready", 32'(p0_req_ready), 32'h0);
    chk("t4_wr_ena", 32'(ram_wr_ena), 32'h1);
    chk("t4_ram_addr", 32'(ram_addr), 32'd8);
    push(1, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t4_p0_ready2", 32'(p0_req_ready), 32'h1);
    push(0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);

    // 5: out-of-range and misaligned accesses are consumed with err and never write
    req(1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1, 32'd0, "t5_oor_rd");
    req(1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b1, 32'd0, "t5_misal_rd");
    req(1, 32'h104, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'd0, "t5_oor_wr");
    req(1, 32'h22, 1'b1, 32'h0000_0BAD, 32'h0, 1'b1, 32'd0, "t5_misal_wr");
    req(1, 32'h20, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 32'd8, "t5_after_misal");
    req(0, 32'hFC, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0, 32'd63, "t5_top_wr");
    req(0, 32'hFC, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'd63, "t5_top_rd");

    // 6: reset mid-grant kills the write and the response, and restores last_grant
    req(0, 32'h8, 1'b1, 32'h2222_2222, 32'h0, 1'b0, 32'd2, "t6_pre");
    @(negedge clk);
    drive(1, 1'b1, 32'h8, 1'b1, 32'hA5A5_A5A5);
    #1;
    chk("t6_p1_ready", 32'(p1_req_ready), 32'h1);
    chk("t6_wr_ena_pre", 32'(ram_wr_ena), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_wr_ena_rst", 32'(ram_wr_ena), 32'h0);
    chk("t6_p1_ready_rst", 32'(p1_req_ready), 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_p1_rsp_dropped", 32'(p1_rsp_valid), 32'h0);
    chk("t6_ram2_unchanged", mem[2], 32'h2222_2222);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 32'h8, 1'b0, 32'h0);
    drive(1, 1'b1, 32'hFC, 1'b0, 32'h0);
    #1;
    chk("t6_first_conflict_p0", 32'(p0_req_ready), 32'h1);
    chk("t6_first_conflict_p1", 32'(p1_req_ready), 32'h0);
    push(0, 32'h2222_2222, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t6_p1_next", 32'(p1_req_ready), 32'h1);
    push(1, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("p0_pending_rsp", 32'(q0.size()), 32'h0);
    chk("p1_pending_rsp", 32'(q1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
